vga_line_fetch: RTL

- Upstream feeder for the VGA scan-out stage.
- On each line-fetch request from the scan-out timing, reads one display line of RGB565 pixels from the frame buffer through a burst-read memory port.
- Writes the pixels into ping-pong line buffer A or B, so the scan-out stage can read one buffer while the other fills.
- Runs entirely in the pixel-clock domain; the memory arbiter owns any clock crossing.

---
 rtl/vga_line_fetch.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/vga_line_fetch.sv
// rtl/vga_line_fetch.sv - fetches one RGB565 display line per request into ping-pong line buffers
module vga_line_fetch #(
  parameter int BURST_LEN  = 256,
  parameter int ADDR_W     = 24,
  parameter int LINE_SHIFT = 10
) (
  input  logic              vga_clk,
  input  logic              rst_n_w,
  input  logic              vga_mode,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              read_buff_req,
  input  logic              read_buff_A_B,
  input  logic [9:0]        read_buff_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [10:0]       mem_len,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  output logic              buff_wr_en_A,
  output logic              buff_wr_en_B,
  output logic [9:0]        buff_wr_addr,
  output logic [15:0]       buff_wr_data,
  output logic              busy,
  output logic              line_done,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam logic [1:0]  S_IDLE = 2'd0;
  localparam logic [1:0]  S_REQ  = 2'd1;
  localparam logic [1:0]  S_DATA = 2'd2;
  localparam logic [1:0]  S_DONE = 2'd3;
  localparam logic [10:0] BURST  = 11'(BURST_LEN);

  logic [1:0]        state_q, state_d;
  logic              req_q;
  logic [9:0]        line_q, line_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [10:0]       len_q, len_d;
  logic [10:0]       pix_cnt_q, pix_cnt_d;
  logic [10:0]       beat_cnt_q, beat_cnt_d;
  logic [10:0]       discard_q, discard_d;
  logic              overrun_q, overrun_d;
  logic              wr_en_a_q, wr_en_a_d;
  logic              wr_en_b_q, wr_en_b_d;
  logic [9:0]        wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;

  logic              req_rise;
  logic              active;
  logic              absorb;
  logic              beat;
  logic [10:0]       remain;
  logic [10:0]       cur_len;
  logic [ADDR_W-1:0] cur_addr;
  logic [10:0]       outstanding;

  assign req_rise = read_buff_req & ~req_q;
  assign active   = (state_q == S_REQ) || (state_q == S_DATA);
  assign remain   = len_q - pix_cnt_q;
  assign cur_len  = (remain > BURST) ? BURST : remain;
  assign cur_addr = base_q + (ADDR_W'(line_q) << LINE_SHIFT) + ADDR_W'(pix_cnt_q);

  // Stale beats of an abandoned burst are swallowed before any new data counts.
  assign absorb = mem_rvalid && (discard_q != 11'd0);
  assign beat   = mem_rvalid && (discard_q == 11'd0) && (state_q == S_DATA);

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    sel_d       = sel_q;
    base_d      = base_q;
    len_d       = len_q;
    pix_cnt_d   = pix_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    discard_d   = discard_q - 11'(absorb);
    overrun_d   = overrun_q & ~overrun_clr;
    wr_en_a_d   = 1'b0;
    wr_en_b_d   = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    outstanding = 11'd0;

    case (state_q)
      S_REQ: begin
        if (mem_ack) begin
          beat_cnt_d = cur_len;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (beat) begin
          wr_en_a_d  = ~sel_q;
          wr_en_b_d  = sel_q;
          wr_addr_d  = pix_cnt_q[9:0];
          wr_data_d  = mem_rdata;
          pix_cnt_d  = pix_cnt_q + 11'd1;
          beat_cnt_d = beat_cnt_q - 11'd1;
          if (beat_cnt_q == 11'd1) begin
            state_d = ((pix_cnt_q + 11'd1) < len_q) ? S_REQ : S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = state_q;
    endcase

    if (req_rise) begin
      line_d     = read_buff_addr;
      sel_d      = read_buff_A_B;
      base_d     = fb_base;
      len_d      = vga_mode ? 11'd1024 : 11'd640;
      pix_cnt_d  = 11'd0;
      beat_cnt_d = 11'd0;
      wr_en_a_d  = 1'b0;
      wr_en_b_d  = 1'b0;
      state_d    = S_REQ;
      if (active) begin
        // A beat arriving in this very cycle belongs to the abandoned line.
        if (state_q == S_DATA) outstanding = beat_cnt_q - 11'(beat);
        else if (mem_ack)      outstanding = cur_len;
        discard_d = discard_q - 11'(absorb) + outstanding;
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n_w) begin
    if (!rst_n_w) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      line_q     <= '0;
      sel_q      <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      pix_cnt_q  <= '0;
      beat_cnt_q <= '0;
      discard_q  <= '0;
      overrun_q  <= 1'b0;
      wr_en_a_q  <= 1'b0;
      wr_en_b_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= read_buff_req;
      line_q     <= line_d;
      sel_q      <= sel_d;
      base_q     <= base_d;
      len_q      <= len_d;
      pix_cnt_q  <= pix_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      discard_q  <= discard_d;
      overrun_q  <= overrun_d;
      wr_en_a_q  <= wr_en_a_d;
      wr_en_b_q  <= wr_en_b_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign mem_req      = (state_q == S_REQ);
  assign mem_addr     = mem_req ? cur_addr : '0;
  assign mem_len      = mem_req ? cur_len : 11'd0;
  assign buff_wr_en_A = wr_en_a_q;
  assign buff_wr_en_B = wr_en_b_q;
  assign buff_wr_addr = wr_addr_q;
  assign buff_wr_data = wr_data_q;
  assign busy         = active;
  assign line_done    = (state_q == S_DONE);
  assign overrun      = overrun_q;

endmodule
